// File: rtl/mem_arbiter_rr_if.sv
// Bundle of requester-side and memory-side signals around mem_arbiter_rr.
// The slave modport is the arbiter's view: it serves the requesters and drives
// the downstream memory port. The master modport is the surrounding system
// (caches plus memory model) that drives requests and memory responses.
interface mem_arbiter_rr_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    // requester side
    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
    logic [LINE_WIDTH-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]            req_resp;

    // downstream memory side
    logic                            mem_read;
    logic                            mem_write;
    logic [ADDR_WIDTH-1:0]           mem_address;
    logic [LINE_WIDTH-1:0]           mem_wdata;
    logic [LINE_WIDTH-1:0]           mem_rdata;
    logic                            mem_resp;

    modport slave (
        input  req_read,
        input  req_write,
        input  req_address,
        input  req_wdata,
        output req_rdata,
        output req_resp,
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        input  mem_rdata,
        input  mem_resp
    );

    modport master (
        output req_read,
        output req_write,
        output req_address,
        output req_wdata,
        input  req_rdata,
        input  req_resp,
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        output mem_rdata,
        output mem_resp
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter merging NUM_PORTS line-granular requesters onto a single
// downstream memory port, one transaction outstanding at a time.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | nothing in flight; pick next pending port after last_grant, latch it
// BUSY  | latched request driven downstream; waiting for mem_resp
module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_arbiter_rr_if.slave bus
);
    localparam int GW = $clog2(NUM_PORTS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_PORTS-1:0]  pending;
    logic                  found;
    logic [GW-1:0]         sel;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_wdata;
    logic [NUM_PORTS-1:0]  req_resp;

    // Rotating-priority search: ports above last_grant first, then wrap to the
    // ports at or below it, so the most recently served port is tried last.
    always_comb begin
        pending = bus.req_read | bus.req_write;
        found   = 1'b0;
        sel     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!found && pending[p] && (GW'(p) > last_grant_q)) begin
                found = 1'b1;
                sel   = GW'(p);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!found && pending[p] && (GW'(p) <= last_grant_q)) begin
                found = 1'b1;
                sel   = GW'(p);
            end
        end
    end

    // Mux out the selected port's request; read+write together counts as write.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel == GW'(p)) begin
                sel_write = bus.req_write[p];
                sel_addr  = bus.req_address[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[p*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    // Next-state logic: capture the winner in IDLE, release it on mem_resp.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_BUSY;
                    grant_d    = sel;
                    op_write_d = sel_write;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                end
            end
            ST_BUSY: begin
                if (bus.mem_resp) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Completion goes straight back to the granted port in the mem_resp cycle.
    always_comb begin
        req_resp = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if ((state_q == ST_BUSY) && bus.mem_resp && (grant_q == GW'(p))) begin
                req_resp[p] = 1'b1;
            end
        end
    end

    assign bus.req_resp    = req_resp;
    assign bus.req_rdata   = bus.mem_rdata;
    assign bus.mem_read    = (state_q == ST_BUSY) && !op_write_q;
    assign bus.mem_write   = (state_q == ST_BUSY) && op_write_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr with four ports: directed scenarios followed by a
// randomized phase, all checked against a transaction-level round-robin model.
module tb_mem_arbiter_rr;
    localparam int NP = 4;
    localparam int AW = 16;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    int   mdl_last;

    mem_arbiter_rr_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bif ();

    mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next winner: first requesting port strictly after the last served one.
    function automatic int mdl_pick(input logic [NP-1:0] pend);
        for (int i = 1; i <= NP; i++) begin
            int p;
            p = (mdl_last + i) % NP;
            if (pend[p]) return p;
        end
        return -1;
    endfunction

    task automatic set_req(input int p, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [LW-1:0] d);
        bif.req_read[p]            = r;
        bif.req_write[p]           = w;
        bif.req_address[p*AW +: AW] = a;
        bif.req_wdata[p*LW +: LW]   = d;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bif.req_read    = '0;
        bif.req_write   = '0;
        bif.req_address = '0;
        bif.req_wdata   = '0;
        bif.mem_rdata   = '0;
        bif.mem_resp    = 1'b0;
        mdl_last        = NP - 1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction from the current (IDLE) negedge through to the IDLE
    // cycle after completion. mutate: requester changes its inputs and drops
    // its request mid-transaction. rearm: requester re-raises after completion.
    task automatic run_txn(input int lat, input bit mutate, input bit rearm,
                           input logic [LW-1:0] rdata);
        logic [NP-1:0] pend;
        logic [NP-1:0] onehot;
        int            g;
        bit            orig_r, orig_w;
        logic [AW-1:0] exp_a;
        logic [LW-1:0] exp_d;
        pend = bif.req_read | bif.req_write;
        g = mdl_pick(pend);
        if (g < 0) return;
        orig_r = bif.req_read[g];
        orig_w = bif.req_write[g];
        exp_a  = bif.req_address[g*AW +: AW];
        exp_d  = bif.req_wdata[g*LW +: LW];
        onehot    = '0;
        onehot[g] = 1'b1;

        @(negedge clk);
        chk("busy_mem_read", bif.mem_read, !orig_w);
        chk("busy_mem_write", bif.mem_write, orig_w);
        chk("busy_mem_address", bif.mem_address, exp_a);
        if (orig_w) chk("busy_mem_wdata", bif.mem_wdata, exp_d);
        chk("busy_req_resp", bif.req_resp, '0);
        if (mutate) begin
            bif.req_address[g*AW +: AW] = 16'hFFFF;
            bif.req_wdata[g*LW +: LW]   = ~exp_d;
            bif.req_read[g]  = 1'b0;
            bif.req_write[g] = 1'b0;
        end
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            chk("hold_mem_read", bif.mem_read, !orig_w);
            chk("hold_mem_write", bif.mem_write, orig_w);
            chk("hold_mem_address", bif.mem_address, exp_a);
            chk("hold_mem_wdata", bif.mem_wdata, exp_d);
            chk("hold_req_resp", bif.req_resp, '0);
        end

        bif.mem_rdata = rdata;
        bif.mem_resp  = 1'b1;
        #1;
        chk("resp_req_resp", bif.req_resp, onehot);
        chk("resp_req_rdata", bif.req_rdata, rdata);
        chk("resp_mem_address", bif.mem_address, exp_a);
        chk("resp_mem_wdata", bif.mem_wdata, exp_d);
        if (rearm) begin
            bif.req_read[g]  = orig_r;
            bif.req_write[g] = orig_w;
        end else begin
            bif.req_read[g]  = 1'b0;
            bif.req_write[g] = 1'b0;
        end
        mdl_last = g;

        @(negedge clk);
        bif.mem_resp  = 1'b0;
        bif.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        chk("after_mem_read", bif.mem_read, 1'b0);
        chk("after_mem_write", bif.mem_write, 1'b0);
        chk("after_req_resp", bif.req_resp, '0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bif.req_read    = '0;
        bif.req_write   = '0;
        bif.req_address = '0;
        bif.req_wdata   = '0;
        bif.mem_rdata   = '0;
        bif.mem_resp    = 1'b0;
        mdl_last        = NP - 1;

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_read", bif.mem_read, 1'b0);
        chk("rst_mem_write", bif.mem_write, 1'b0);
        chk("rst_mem_address", bif.mem_address, '0);
        chk("rst_mem_wdata", bif.mem_wdata, '0);
        chk("rst_req_resp", bif.req_resp, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // single read from port 0
        set_req(0, 1'b1, 1'b0, 16'h1234, '0);
        run_txn(1, 1'b0, 1'b0, {16{8'hA5}});

        // ports 0 and 1 together from reset, then again: alternation
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0100, '0);
        set_req(1, 1'b1, 1'b0, 16'h0200, '0);
        run_txn(2, 1'b0, 1'b0, {4{$urandom}});
        run_txn(1, 1'b0, 1'b0, {4{$urandom}});
        set_req(0, 1'b1, 1'b0, 16'h0300, '0);
        set_req(1, 1'b1, 1'b0, 16'h0400, '0);
        run_txn(1, 1'b0, 1'b0, {4{$urandom}});
        run_txn(1, 1'b0, 1'b0, {4{$urandom}});

        // all four continuously requesting, then only ports 1 and 3
        do_reset();
        for (int p = 0; p < NP; p++)
            set_req(p, 1'b1, 1'b0, AW'(16'h1000 + p), {4{$urandom}});
        for (int i = 0; i < 5; i++)
            run_txn(1 + i % 2, 1'b0, 1'b1, {4{$urandom}});
        bif.req_read = '0;
        set_req(1, 1'b1, 1'b0, 16'h2001, '0);
        set_req(3, 1'b1, 1'b0, 16'h2003, '0);
        run_txn(1, 1'b0, 1'b0, {4{$urandom}});
        run_txn(1, 1'b0, 1'b0, {4{$urandom}});

        // port 1 write; requester changes address/data and drops mid-flight
        set_req(1, 1'b0, 1'b1, 16'h0040, {4{32'hDEADBEEF}});
        run_txn(3, 1'b1, 1'b0, {4{$urandom}});

        // stray mem_resp while idle
        bif.mem_resp = 1'b1;
        #1;
        chk("stray_req_resp", bif.req_resp, '0);
        @(negedge clk);
        chk("stray_mem_read", bif.mem_read, 1'b0);
        chk("stray_mem_write", bif.mem_write, 1'b0);
        bif.mem_resp = 1'b0;

        // reset mid-BUSY: strobe drops immediately, next grant restarts at port 0
        set_req(2, 1'b1, 1'b0, 16'h0222, '0);
        set_req(0, 1'b1, 1'b0, 16'h0111, '0);
        @(negedge clk);
        chk("prerst_mem_read", bif.mem_read, 1'b1);
        chk("prerst_mem_address", bif.mem_address, 16'h0222);
        #2;
        rst_n = 1'b0;
        #1;
        chk("asyncrst_mem_read", bif.mem_read, 1'b0);
        chk("asyncrst_req_resp", bif.req_resp, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        mdl_last = NP - 1;
        run_txn(1, 1'b0, 1'b0, {4{$urandom}});
        run_txn(2, 1'b0, 1'b0, {4{$urandom}});

        // read and write together on port 0 resolves to a write
        set_req(0, 1'b1, 1'b1, 16'h0010, {4{$urandom}});
        run_txn(1, 1'b0, 1'b0, {4{$urandom}});

        // randomized traffic
        for (int it = 0; it < 200; it++) begin
            for (int p = 0; p < NP; p++) begin
                if (!(bif.req_read[p] | bif.req_write[p]) && $urandom_range(0, 2) == 0) begin
                    int rw;
                    rw = $urandom_range(1, 3);
                    set_req(p, rw[0], rw[1], AW'($urandom), {4{$urandom}});
                end
            end
            if ((bif.req_read | bif.req_write) != '0) begin
                run_txn($urandom_range(1, 4), $urandom_range(0, 3) == 0,
                        $urandom_range(0, 1) == 1, {4{$urandom}});
            end else begin
                bif.mem_resp = 1'($urandom_range(0, 1));
                #1;
                chk("rand_idle_req_resp", bif.req_resp, '0);
                @(negedge clk);
                chk("rand_idle_mem_read", bif.mem_read, 1'b0);
                chk("rand_idle_mem_write", bif.mem_write, 1'b0);
                bif.mem_resp = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised round-robin memory arbiter that merges NUM_PORTS line-granular requesters (I-cache, D-cache, future prefetch/victim ports) onto one downstream memory port (L2 or physical memory). It generalises the fixed two-port instruction/data arbiter to N ports with fair rotating priority and latched request capture. It sits between the L1 caches and the next memory level, one transaction outstanding at a time.

## Interface
- NUM_PORTS, 2, number of requester ports (>= 2)
- ADDR_WIDTH, 16, address width
- LINE_WIDTH, 128, line data width
- GW (localparam), $clog2(NUM_PORTS), grant index width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_read  in  NUM_PORTS  per-port read request, held until that port's req_resp
- req_write  in  NUM_PORTS  per-port write request, held until req_resp
- req_address  in  NUM_PORTS*ADDR_WIDTH  port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_PORTS*LINE_WIDTH  port i at bits [i*LINE_WIDTH +: LINE_WIDTH]
- req_rdata  out  LINE_WIDTH  shared read data, valid only with a req_resp bit
- req_resp  out  NUM_PORTS  one-hot completion, one cycle
- mem_read  out  1  downstream read
- mem_write  out  1  downstream write
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  LINE_WIDTH  downstream write data
- mem_rdata  in  LINE_WIDTH  downstream read data
- mem_resp  in  1  downstream completion, one cycle

## Operation
- States: IDLE, BUSY.
- IDLE: compute pending = req_read | req_write. If nonzero, select first set bit searching from (last_grant+1) mod NUM_PORTS upward with wrap; register grant, latch that port's address, wdata, and op (write if req_write set, else read); go BUSY.
- Port asserting read and write together: illegal; arbiter treats it as write.
- BUSY: mem_read/mem_write driven from latched op, mem_address/mem_wdata from latched values; requester inputs ignored. On mem_resp: req_resp[grant]=1 combinationally, req_rdata=mem_rdata pass-through, last_grant<=grant, go IDLE.
- Requester dropping its request mid-transaction: transaction still completes downstream; req_resp still pulses.
- mem_resp in IDLE: ignored, no req_resp.
- Reset values: state IDLE, last_grant=NUM_PORTS-1 (port 0 highest priority first), latched address/wdata 0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, req_resp=0. req_rdata follows mem_rdata (don't-care without resp).
- Reset asserted mid-BUSY: immediate return to IDLE, downstream strobes drop asynchronously; in-flight transaction abandoned, no req_resp.

## Timing
- Request high in IDLE cycle t: mem_read/mem_write high from cycle t+1 (registered).
- mem_resp in cycle k: req_resp same cycle k; mem strobes low in k+1 (IDLE).
- Minimum one IDLE cycle between transactions; earliest next downstream strobe k+2.
- Back-to-back latency per transaction: downstream latency + 1 cycle.
- Fairness: with all ports requesting continuously, each port granted once per NUM_PORTS transactions; maximum wait NUM_PORTS-1 transactions.
- req_resp never has more than one bit set; never asserted outside BUSY.

## Test plan
- Reset, NUM_PORTS=2: all outputs 0; port 0 read addr 0x1234 -> mem_read=1, mem_address=0x1234 next cycle; mem_resp with mem_rdata=0xA5..A5 -> req_resp=2'b01, req_rdata=0xA5..A5 same cycle, mem_read=0 next cycle.
- Ports 0 and 1 request simultaneously from reset -> port 0 served first, then port 1; repeat -> port 0 again (alternation).
- NUM_PORTS=4, all ports requesting continuously -> grant order 0,1,2,3,0; then only ports 1 and 3 requesting with last_grant=0 -> 1 then 3.
- Port 1 write addr 0x0040 wdata 0xDEAD..BEEF; port changes address to 0xFFFF during BUSY -> mem_address stays 0x0040, mem_write=1, mem_wdata unchanged until resp.
- Stray mem_resp in IDLE -> req_resp stays 0; rst_n pulsed low mid-BUSY -> mem_read drops in same cycle, state IDLE, next grant goes to port 0.
- Port 0 asserts read and write together addr 0x0010 -> mem_write=1, mem_read=0.
